// File: rtl/cnt_bin2bcd.sv
// cnt_bin2bcd - sequential binary-to-BCD converter (double-dabble, one bit
// per clock) for the up/down counter value.
//
// Parameters:
//   UPBND  upper bound of the feeding counter (i_bin > UPBND flags o_ovf)
//   NDIG   number of BCD output digits (10^NDIG must exceed UPBND)
//   BW     derived input width, $clog2(UPBND+1)
//
// Ports:
//   i_clk   clock, rising edge
//   i_rstn  asynchronous active-low reset
//   i_bin   binary count, captured when i_vld && o_rdy
//   i_vld   i_bin valid
//   o_rdy   converter idle, can accept
//   o_bcd   packed BCD, digit 0 in [3:0]; held while o_vld && !i_rdy
//   o_vld   o_bcd valid
//   i_rdy   downstream accepts o_bcd
//   o_ovf   captured value > UPBND (or saturated); qualified by o_vld
//
// Optional feature: define CNT_BCD_ZBLANK_EN for leading-zero blanking
// (leading zero digits above digit 0 output as 4'hF).
module cnt_bin2bcd #(
    parameter int UPBND = 32,
    parameter int NDIG  = 2,
    localparam int BW   = $clog2(UPBND + 1)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [BW-1:0]     i_bin,
    input  logic              i_vld,
    output logic              o_rdy,
    output logic [4*NDIG-1:0] o_bcd,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic              o_ovf
);

    // One guard digit is enough: 2^BW < 2*(UPBND+1) <= 2*10^NDIG, so any
    // BW-bit value fits in NDIG+1 digits and the guard digit flags saturation.
    localparam int AW = 4 * (NDIG + 1);
    localparam int CW = $clog2(BW + 1);
    localparam logic [BW-1:0] UPBND_V = BW'(UPBND);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [BW-1:0]     sh;
    logic [AW-1:0]     acc;
    logic [CW-1:0]     cnt;

    logic [AW-1:0]     acc_adj;
    logic [AW-1:0]     acc_nxt;
    logic [BW-1:0]     sh_nxt;
    logic              sat;
    logic [4*NDIG-1:0] bcd_plain;
    logic [4*NDIG-1:0] bcd_fin;

    // Add-3 per digit (no inter-digit carry), then shift {acc,sh} left by one.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < NDIG + 1; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
        acc_nxt   = {acc_adj[AW-2:0], sh[BW-1]};
        sh_nxt    = sh << 1;
        sat       = |acc_nxt[AW-1:4*NDIG];
        bcd_plain = sat ? {NDIG{4'h9}} : acc_nxt[4*NDIG-1:0];
    end

`ifdef CNT_BCD_ZBLANK_EN
    // Blank zero digits above the highest nonzero one; digit 0 always shown.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        bcd_fin = bcd_plain;
        for (int d = NDIG - 1; d >= 1; d--) begin
            if (lead && bcd_plain[4*d +: 4] == 4'h0)
                bcd_fin[4*d +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end
`else
    assign bcd_fin = bcd_plain;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            o_bcd <= '0;
            o_vld <= 1'b0;
            o_ovf <= 1'b0;
            o_rdy <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_vld) begin
                        sh    <= i_bin;
                        acc   <= '0;
                        cnt   <= CW'(BW);
                        o_ovf <= (i_bin > UPBND_V);
                        o_rdy <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    cnt <= cnt - CW'(1);
                    // Last shift: publish the finished result directly.
                    if (cnt == CW'(1)) begin
                        o_bcd <= bcd_fin;
                        o_ovf <= o_ovf | sat;
                        o_vld <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        o_vld <= 1'b0;
                        o_rdy <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_bin2bcd.sv
// tb_cnt_bin2bcd - scoreboard bench for cnt_bin2bcd: default instance
// (UPBND=32, NDIG=2, BW=6) and a second instance (UPBND=99, NDIG=2, BW=7).
// Expected results are hand-computed and pushed at issue time; a monitor per
// instance pops and compares on each output handshake.
module tb_cnt_bin2bcd;

    typedef struct packed {
        logic [7:0] bcd;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;

    logic [5:0] bin_a = '0;
    logic       vld_a = 1'b0;
    logic       rdy_a = 1'b1;
    logic       ordy_a, ovld_a, oovf_a;
    logic [7:0] bcd_a;

    logic [6:0] bin_b = '0;
    logic       vld_b = 1'b0;
    logic       rdy_b = 1'b1;
    logic       ordy_b, ovld_b, oovf_b;
    logic [7:0] bcd_b;

    int n_chk = 0;
    int n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    cnt_bin2bcd #(.UPBND(32), .NDIG(2)) u_a (
        .i_clk(clk), .i_rstn(rstn), .i_bin(bin_a), .i_vld(vld_a),
        .o_rdy(ordy_a), .o_bcd(bcd_a), .o_vld(ovld_a), .i_rdy(rdy_a),
        .o_ovf(oovf_a)
    );

    cnt_bin2bcd #(.UPBND(99), .NDIG(2)) u_b (
        .i_clk(clk), .i_rstn(rstn), .i_bin(bin_b), .i_vld(vld_b),
        .o_rdy(ordy_b), .o_bcd(bcd_b), .o_vld(ovld_b), .i_rdy(rdy_b),
        .o_ovf(oovf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected display form of a two-digit hand-computed BCD value.
    function automatic logic [7:0] disp(input logic [7:0] b);
`ifdef CNT_BCD_ZBLANK_EN
        if (b[7:4] == 4'h0) return {4'hF, b[3:0]};
`endif
        return b;
    endfunction

    // Monitor A: compare on handshake, check hold stability under backpressure.
    logic       held_a = 1'b0;
    logic [7:0] hbcd_a;
    logic       hovf_a;
    always @(negedge clk) begin
        if (!rstn) begin
            held_a = 1'b0;
        end else if (ovld_a) begin
            if (held_a) begin
                check("a_hold_bcd", 32'(bcd_a), 32'(hbcd_a));
                check("a_hold_ovf", 32'(oovf_a), 32'(hovf_a));
            end
            if (rdy_a) begin
                held_a = 1'b0;
                if (q_a.size() == 0) begin
                    check("a_unexpected_out", 32'(bcd_a), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_bcd", 32'(bcd_a), 32'(e.bcd));
                    check("a_ovf", 32'(oovf_a), 32'(e.ovf));
                end
            end else begin
                held_a = 1'b1;
                hbcd_a = bcd_a;
                hovf_a = oovf_a;
            end
        end else begin
            held_a = 1'b0;
        end
    end

    // Monitor B: handshake compare only (i_rdy held high on this instance).
    always @(negedge clk) begin
        if (rstn && ovld_b && rdy_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_out", 32'(bcd_b), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_bcd", 32'(bcd_b), 32'(e.bcd));
                check("b_ovf", 32'(oovf_b), 32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one value to instance A; checks latency and, if i_rdy is high,
    // o_rdy returning the cycle after o_vld.
    task automatic conv_a(input logic [5:0] b, input logic [7:0] exp_bcd, input logic exp_ovf);
        int k;
        k = 0;
        while (!ordy_a && k < 50) begin tick(); k++; end
        check("a_wait_rdy", 32'(ordy_a), 32'd1);
        q_a.push_back('{bcd: disp(exp_bcd), ovf: exp_ovf});
        bin_a = b;
        vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        bin_a = 6'h3F;  // post-capture change must not matter
        k = 0;
        while (!ovld_a && k < 20) begin tick(); k++; end
        check("a_latency", 32'(k), 32'd6);
        if (rdy_a) begin
            tick();
            check("a_rdy_after", 32'(ordy_a), 32'd1);
            check("a_vld_after", 32'(ovld_a), 32'd0);
        end
    endtask

    task automatic conv_b(input logic [6:0] b, input logic [7:0] exp_bcd, input logic exp_ovf);
        int k;
        q_b.push_back('{bcd: disp(exp_bcd), ovf: exp_ovf});
        bin_b = b;
        vld_b = 1'b1;
        tick();
        vld_b = 1'b0;
        k = 0;
        while (!ovld_b && k < 20) begin tick(); k++; end
        check("b_latency", 32'(k), 32'd7);
        tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_bcd", 32'(bcd_a), 32'h00);
        check("rst_vld", 32'(ovld_a), 32'd0);
        check("rst_rdy", 32'(ordy_a), 32'd1);
        check("rst_ovf", 32'(oovf_a), 32'd0);
        rstn = 1'b1;
        repeat (3) tick();
        check("idle_vld", 32'(ovld_a), 32'd0);
        check("idle_rdy", 32'(ordy_a), 32'd1);

        // Main conversions, i_rdy high
        conv_a(6'd27, 8'h27, 1'b0);
        conv_a(6'd32, 8'h32, 1'b0);   // i_bin == UPBND: no overflow
        conv_a(6'd0,  8'h00, 1'b0);
        conv_a(6'd5,  8'h05, 1'b0);
        conv_a(6'd30, 8'h30, 1'b0);
        conv_a(6'd45, 8'h45, 1'b1);
        conv_a(6'd63, 8'h63, 1'b1);

        // Backpressure: hold 09 for 5 cycles, ignore i_vld=13 meanwhile
        rdy_a = 1'b0;
        conv_a(6'd9, 8'h09, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("bp_vld", 32'(ovld_a), 32'd1);
            check("bp_rdy", 32'(ordy_a), 32'd0);
            if (c == 2) begin bin_a = 6'd13; vld_a = 1'b1; end
            else vld_a = 1'b0;
            tick();
        end
        vld_a = 1'b0;
        rdy_a = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            check("bp_not_queued", 32'(ovld_a), 32'd0);
            tick();
        end
        conv_a(6'd13, 8'h13, 1'b0);

        // Reset mid-SHIFT, then a fresh conversion
        bin_a = 6'd27;
        vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        check("mid_rst_vld", 32'(ovld_a), 32'd0);
        check("mid_rst_bcd", 32'(bcd_a), 32'h00);
        check("mid_rst_rdy", 32'(ordy_a), 32'd1);
        tick();
        rstn = 1'b1;
        tick();
        conv_a(6'd18, 8'h18, 1'b0);

        // Second instance: UPBND=99, saturation above 99
        conv_b(7'd99,  8'h99, 1'b0);
        conv_b(7'd120, 8'h99, 1'b1);
        conv_b(7'd100, 8'h99, 1'b1);
        conv_b(7'd7,   8'h07, 1'b0);

        repeat (4) tick();
        check("q_a_drained", 32'(q_a.size()), 32'd0);
        check("q_b_drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
